// File: rtl/arbiter_stream_mux.sv
// Packet-granular stream mux behind an external round-robin arbiter.
// Holds a grant for a whole packet, then drops its request once so the arbiter token moves on.
module arbiter_stream_mux #(
    parameter int unsigned NUM_PORTS  = 6,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned PORT_WIDTH = 3
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] up_data,
    input  logic [NUM_PORTS-1:0]            up_valid,
    input  logic [NUM_PORTS-1:0]            up_last,
    output logic [NUM_PORTS-1:0]            up_ready,
    output logic [0:NUM_PORTS-1]            request,
    input  logic [0:NUM_PORTS-1]            grant,
    input  logic                            active,
    output logic [DATA_WIDTH-1:0]           down_data,
    output logic                            down_valid,
    output logic                            down_last,
    output logic [PORT_WIDTH-1:0]           down_port,
    input  logic                            down_ready
);

    typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

    state_t                  state;
    logic [PORT_WIDTH-1:0]   owner;
    logic [PORT_WIDTH-1:0]   grant_idx;
    logic [NUM_PORTS-1:0]    hold_off;
    logic                    owner_grant;
    logic                    owner_valid;
    logic                    owner_last;
    logic [DATA_WIDTH-1:0]   owner_data;
    logic                    out_free;
    logic                    accept;

    // Per-owner views of the upstream and grant vectors.
    always_comb begin : owner_sel
        owner_grant = 1'b0;
        owner_valid = 1'b0;
        owner_last  = 1'b0;
        owner_data  = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (owner == PORT_WIDTH'(i)) begin
                owner_grant = grant[i];
                owner_valid = up_valid[i];
                owner_last  = up_last[i];
                owner_data  = up_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Lowest set grant bit wins if the arbiter ever shows more than one.
    always_comb begin : grant_enc
        grant_idx = '0;
        for (int i = int'(NUM_PORTS) - 1; i >= 0; i--) begin
            if (grant[i]) begin
                grant_idx = PORT_WIDTH'(i);
            end
        end
    end

    assign out_free = ~down_valid | down_ready;
    assign accept   = (state == BUSY) & owner_grant & out_free & owner_valid;

    // Owner keeps requesting through valid bubbles; reset forces requests low.
    always_comb begin : req_rdy
        request  = '0;
        up_ready = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            request[i]  = rst & (up_valid[i] | ((state == BUSY) && (owner == PORT_WIDTH'(i))))
                              & ~hold_off[i];
            up_ready[i] = (state == BUSY) && (owner == PORT_WIDTH'(i)) && grant[i] && out_free;
        end
    end

    always_ff @(posedge clk or negedge rst) begin : fsm
        if (!rst) begin
            state    <= IDLE;
            owner    <= '0;
            hold_off <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (active) begin
                        owner <= grant_idx;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (!owner_grant) begin
                        state <= IDLE;
                    end else if (accept && owner_last) begin
                        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                            if (owner == PORT_WIDTH'(i)) hold_off[i] <= 1'b1;
                        end
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!owner_grant) begin
                        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                            if (owner == PORT_WIDTH'(i)) hold_off[i] <= 1'b0;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Single output stage; contents hold while stalled.
    always_ff @(posedge clk or negedge rst) begin : out_reg
        if (!rst) begin
            down_data  <= '0;
            down_last  <= 1'b0;
            down_port  <= '0;
            down_valid <= 1'b0;
        end else if (accept) begin
            down_data  <= owner_data;
            down_last  <= owner_last;
            down_port  <= owner;
            down_valid <= 1'b1;
        end else if (down_ready) begin
            down_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_arbiter_stream_mux.sv
// Directed bench for arbiter_stream_mux with a behavioural round-robin arbiter alongside.
module tb_arbiter_stream_mux;

    localparam int unsigned NP   = 6;
    localparam int unsigned DW   = 32;
    localparam int unsigned PW   = 3;
    localparam int          LOGN = 256;

    logic                clk = 1'b0;
    logic                rst;
    logic [NP*DW-1:0]    up_data;
    logic [NP-1:0]       up_valid;
    logic [NP-1:0]       up_last;
    logic [NP-1:0]       up_ready;
    logic [0:NP-1]       request;
    logic [0:NP-1]       gnt_a;
    logic                active_a;
    logic [DW-1:0]       down_data;
    logic                down_valid;
    logic                down_last;
    logic [PW-1:0]       down_port;
    logic                down_ready;

    logic [DW-1:0]       up_data_b;
    logic [0:0]          up_valid_b;
    logic [0:0]          up_last_b;
    logic [0:0]          up_ready_b;
    logic [0:0]          request_b;
    logic [0:0]          grant_b;
    logic                active_b;
    logic [DW-1:0]       down_data_b;
    logic                down_valid_b;
    logic                down_last_b;
    logic [0:0]          down_port_b;
    logic                down_ready_b;

    always #5 clk = ~clk;

    arbiter_stream_mux #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .PORT_WIDTH(PW)) dut (
        .clk(clk), .rst(rst), .up_data(up_data), .up_valid(up_valid), .up_last(up_last),
        .up_ready(up_ready), .request(request), .grant(gnt_a), .active(active_a),
        .down_data(down_data), .down_valid(down_valid), .down_last(down_last),
        .down_port(down_port), .down_ready(down_ready)
    );

    arbiter_stream_mux #(.NUM_PORTS(1), .DATA_WIDTH(DW), .PORT_WIDTH(1)) dut_b (
        .clk(clk), .rst(rst), .up_data(up_data_b), .up_valid(up_valid_b), .up_last(up_last_b),
        .up_ready(up_ready_b), .request(request_b), .grant(grant_b), .active(active_b),
        .down_data(down_data_b), .down_valid(down_valid_b), .down_last(down_last_b),
        .down_port(down_port_b), .down_ready(down_ready_b)
    );

    // Round-robin arbiter: holds while the holder requests, else searches after the last winner.
    logic [0:NP-1] nxt_gnt;
    logic [2:0]    last_a;
    logic [2:0]    nxt_last;
    logic          arb_found;
    int            arb_idx;

    always_comb begin
        nxt_gnt   = '0;
        nxt_last  = last_a;
        arb_found = 1'b0;
        arb_idx   = 0;
        if (|(gnt_a & request)) begin
            nxt_gnt = gnt_a;
        end else begin
            for (int k = 1; k <= int'(NP); k++) begin
                arb_idx = (int'(last_a) + k) % int'(NP);
                if (!arb_found && request[arb_idx]) begin
                    arb_found         = 1'b1;
                    nxt_gnt[arb_idx]  = 1'b1;
                    nxt_last          = 3'(arb_idx);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt_a   <= '0;
            last_a  <= 3'(NP - 1);
            grant_b <= '0;
        end else begin
            gnt_a   <= nxt_gnt;
            last_a  <= nxt_last;
            grant_b <= request_b;
        end
    end

    assign active_a = |gnt_a;
    assign active_b = |grant_b;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        logic [PW-1:0] port;
        int            cyc;
    } beat_t;

    beat_t             out_q[$];
    logic [DW+PW:0]    exp_q[$];

    logic [0:NP-1]     log_req [LOGN];
    logic [0:NP-1]     log_gnt [LOGN];
    logic              log_dv  [LOGN];
    logic              log_dl  [LOGN];
    logic [PW-1:0]     log_dp  [LOGN];

    int src_pkts[NP], src_beat[NP], src_len[NP], src_pkt[NP], pause_at[NP], pause_left[NP];
    int stall_at, stall_left, down_cnt, up_cnt, cyc;
    int stab_err, rdy_err, stall_cyc, pause_cyc, pause_req_err, pause_gnt_err;
    logic          prev_stall;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    logic [PW-1:0] prev_port;

    logic          b_en;
    int            b_seq, b_beats, b_bad, b_last_cyc, b_first_cyc, b_min_gap, b_max_gap;
    logic [DW-1:0] b_exp;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk_data(input int p, input int k, input int b);
        return {8'(p), 8'(k), 16'(b)};
    endfunction

    function automatic logic pause_active(input int i);
        return (src_pkts[i] > 0) && (pause_left[i] > 0) && (src_beat[i] == pause_at[i]);
    endfunction

    task automatic expect_pkt(input int p, input int k, input int len);
        for (int b = 0; b < len; b++) begin
            exp_q.push_back({mk_data(p, k, b), (b == len - 1), PW'(p)});
        end
    endtask

    task automatic drive_src();
        for (int i = 0; i < int'(NP); i++) begin
            up_valid[i] = (src_pkts[i] > 0) && !pause_active(i);
            up_last[i]  = (src_beat[i] == src_len[i] - 1);
            up_data[i*DW +: DW] = mk_data(i, src_pkt[i], src_beat[i]);
        end
        down_ready    = !((stall_left > 0) && (down_cnt >= stall_at));
        up_valid_b[0] = b_en;
        up_last_b[0]  = 1'b1;
        up_data_b     = DW'(b_seq);
        down_ready_b  = 1'b1;
    endtask

    // One clock: sample at the falling edge, advance sources just after the rising edge.
    task automatic step();
        logic [NP-1:0] acc;
        logic [NP-1:0] paused;
        logic          b_acc;
        @(negedge clk);
        for (int i = 0; i < int'(NP); i++) begin
            acc[i]    = up_valid[i] & up_ready[i];
            paused[i] = pause_active(i);
        end
        if (cyc < LOGN) begin
            log_req[cyc] = request;
            log_gnt[cyc] = gnt_a;
            log_dv[cyc]  = down_valid;
            log_dl[cyc]  = down_last;
            log_dp[cyc]  = down_port;
        end
        if (prev_stall && (!down_valid || down_data !== prev_data ||
                           down_last !== prev_last || down_port !== prev_port)) stab_err++;
        prev_stall = down_valid & ~down_ready;
        prev_data  = down_data;
        prev_last  = down_last;
        prev_port  = down_port;
        if (down_valid && !down_ready) begin
            stall_cyc++;
            if (|up_ready) rdy_err++;
        end
        if (down_valid && down_ready) begin
            out_q.push_back('{down_data, down_last, down_port, cyc});
            down_cnt++;
        end
        for (int i = 0; i < int'(NP); i++) begin
            if (paused[i]) begin
                pause_cyc++;
                if (!request[i]) pause_req_err++;
                if (!gnt_a[i])   pause_gnt_err++;
            end
        end
        if (down_valid_b) begin
            if (!down_last_b || down_port_b != 1'b0 || down_data_b != b_exp) b_bad++;
            b_exp++;
            if (b_last_cyc >= 0) begin
                if (cyc - b_last_cyc - 1 < b_min_gap) b_min_gap = cyc - b_last_cyc - 1;
                if (cyc - b_last_cyc - 1 > b_max_gap) b_max_gap = cyc - b_last_cyc - 1;
            end else begin
                b_first_cyc = cyc;
            end
            b_last_cyc = cyc;
            b_beats++;
        end
        b_acc = up_valid_b[0] & up_ready_b[0];
        @(posedge clk);
        #1;
        for (int i = 0; i < int'(NP); i++) begin
            if (acc[i]) begin
                up_cnt++;
                if (src_beat[i] == src_len[i] - 1) begin
                    src_pkts[i]--;
                    src_beat[i] = 0;
                    src_pkt[i]++;
                end else begin
                    src_beat[i]++;
                end
            end
            if (paused[i]) pause_left[i]--;
        end
        if (!down_ready && stall_left > 0) stall_left--;
        if (b_acc) b_seq++;
        cyc++;
        drive_src();
    endtask

    task automatic run_scn(input string tag, input int max);
        bit done;
        done = 1'b0;
        for (int n = 0; n < max && !done; n++) begin
            step();
            done = !down_valid;
            for (int i = 0; i < int'(NP); i++) if (src_pkts[i] > 0) done = 1'b0;
        end
        check({tag, "_done"}, 64'(done), 64'd1);
    endtask

    task automatic compare_out(input string tag);
        check({tag, "_count"}, 64'(out_q.size()), 64'(exp_q.size()));
        for (int j = 0; j < out_q.size() && j < exp_q.size(); j++) begin
            check($sformatf("%s_beat%0d", tag, j),
                  64'({out_q[j].data, out_q[j].last, out_q[j].port}), 64'(exp_q[j]));
        end
    endtask

    task automatic reset_all();
        rst = 1'b0;
        for (int i = 0; i < int'(NP); i++) begin
            src_pkts[i] = 0; src_beat[i] = 0; src_len[i] = 1; src_pkt[i] = 0;
            pause_at[i] = -1; pause_left[i] = 0;
        end
        stall_at = 0; stall_left = 0; b_en = 1'b0; b_seq = 0; down_cnt = 0;
        drive_src();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        out_q.delete(); exp_q.delete();
        up_cnt = 0; cyc = 0; prev_stall = 1'b0;
        stab_err = 0; rdy_err = 0; stall_cyc = 0;
        pause_cyc = 0; pause_req_err = 0; pause_gnt_err = 0;
        b_beats = 0; b_bad = 0; b_last_cyc = -1; b_first_cyc = -1;
        b_min_gap = 1000; b_max_gap = 0; b_exp = '0;
    endtask

    initial begin
        // Reset values, with a valid already present to show request is gated.
        rst = 1'b0;
        up_data = '0; up_valid = '0; up_last = '0; down_ready = 1'b1;
        up_data_b = '0; up_valid_b = '0; up_last_b = '0; down_ready_b = 1'b1;
        #2;
        up_valid[0] = 1'b1;
        #1;
        check("rst_down_valid", 64'(down_valid), 64'd0);
        check("rst_down_last",  64'(down_last),  64'd0);
        check("rst_down_data",  64'(down_data),  64'd0);
        check("rst_down_port",  64'(down_port),  64'd0);
        check("rst_up_ready",   64'(up_ready),   64'd0);
        check("rst_request",    64'(request),    64'd0);
        check("rst_b_valid",    64'(down_valid_b), 64'd0);

        // Port 2, two 4-beat packets, sole requester.
        reset_all();
        src_pkts[2] = 2; src_len[2] = 4;
        drive_src();
        expect_pkt(2, 0, 4);
        expect_pkt(2, 1, 4);
        run_scn("s1", 200);
        check("s1_req_c0", 64'(log_req[0][2]), 64'd1);
        check("s1_gnt_c0", 64'(log_gnt[0]),    64'd0);
        check("s1_gnt_c1", 64'(log_gnt[1][2]), 64'd1);
        check("s1_dv_c2",  64'(log_dv[2]),     64'd0);
        for (int c = 3; c <= 6; c++) begin
            check($sformatf("s1_dv_c%0d", c),   64'(log_dv[c]), 64'd1);
            check($sformatf("s1_port_c%0d", c), 64'(log_dp[c]), 64'd2);
            check($sformatf("s1_last_c%0d", c), 64'(log_dl[c]), 64'(c == 6));
        end
        check("s1_dv_c7",  64'(log_dv[7]),     64'd0);
        check("s1_req_c6", 64'(log_req[6][2]), 64'd0);
        check("s1_req_c7", 64'(log_req[7][2]), 64'd0);
        check("s1_req_c8", 64'(log_req[8][2]), 64'd1);
        compare_out("s1");

        // Ports 0, 1, 3 with two 2-beat packets each: token order and 3-cycle gaps.
        reset_all();
        foreach (src_pkts[i]) if (i == 0 || i == 1 || i == 3) begin
            src_pkts[i] = 2; src_len[i] = 2;
        end
        drive_src();
        for (int k = 0; k < 2; k++) begin
            expect_pkt(0, k, 2); expect_pkt(1, k, 2); expect_pkt(3, k, 2);
        end
        run_scn("s2", 300);
        compare_out("s2");
        if (out_q.size() == exp_q.size()) begin
            for (int j = 1; j < out_q.size(); j++) begin
                check($sformatf("s2_gap%0d", j), 64'(out_q[j].cyc - out_q[j-1].cyc - 1),
                      out_q[j-1].last ? 64'd3 : 64'd0);
            end
        end

        // Port 5, 6-beat packet, down_ready low for 5 cycles after two beats.
        reset_all();
        src_pkts[5] = 1; src_len[5] = 6;
        stall_at = 2; stall_left = 5;
        drive_src();
        expect_pkt(5, 0, 6);
        run_scn("s3", 200);
        compare_out("s3");
        check("s3_stall_cycles", 64'(stall_cyc), 64'd5);
        check("s3_stable",       64'(stab_err),  64'd0);
        check("s3_no_up_ready",  64'(rdy_err),   64'd0);
        check("s3_up_beats",     64'(up_cnt),    64'd6);
        check("s3_down_beats",   64'(down_cnt),  64'd6);

        // Owner port 1 pauses 3 cycles mid-packet while port 3 waits.
        reset_all();
        src_pkts[1] = 1; src_len[1] = 4; pause_at[1] = 2; pause_left[1] = 3;
        src_pkts[3] = 1; src_len[3] = 2;
        drive_src();
        expect_pkt(1, 0, 4);
        expect_pkt(3, 0, 2);
        run_scn("s4", 200);
        compare_out("s4");
        check("s4_pause_cycles", 64'(pause_cyc),     64'd3);
        check("s4_req_held",     64'(pause_req_err), 64'd0);
        check("s4_gnt_held",     64'(pause_gnt_err), 64'd0);

        // Reset mid-packet on port 4, then a clean packet from port 1.
        reset_all();
        src_pkts[4] = 1; src_len[4] = 6;
        drive_src();
        for (int n = 0; n < 30 && down_cnt < 2; n++) step();
        check("s5_reached_mid", 64'(down_cnt >= 2), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        check("s5_rst_down_valid", 64'(down_valid), 64'd0);
        check("s5_rst_up_ready",   64'(up_ready),   64'd0);
        check("s5_rst_request",    64'(request),    64'd0);
        check("s5_rst_down_data",  64'(down_data),  64'd0);
        reset_all();
        src_pkts[1] = 1; src_len[1] = 3;
        drive_src();
        expect_pkt(1, 0, 3);
        run_scn("s5", 200);
        compare_out("s5");
        check("s5_dv_c2",   64'(log_dv[2]), 64'd0);
        check("s5_dv_c3",   64'(log_dv[3]), 64'd1);
        check("s5_port_c3", 64'(log_dp[3]), 64'd1);

        // Single-port instance, back-to-back single-beat packets.
        reset_all();
        b_en = 1'b1;
        drive_src();
        repeat (40) step();
        b_en = 1'b0;
        drive_src();
        check("s6_first_cyc",  64'(b_first_cyc),           64'd3);
        check("s6_beats",      64'(b_beats >= 6),          64'd1);
        check("s6_beat_bad",   64'(b_bad),                 64'd0);
        check("s6_gap_min",    64'(b_min_gap >= 3),        64'd1);
        check("s6_gap_steady", 64'(b_min_gap == b_max_gap), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/arbiter_stream_mux.md
Name: arbiter_stream_mux

Overview:
- Downstream consumer of the round-robin arbiter: drives the arbiter's `request` vector and consumes its registered `grant`/`active`.
- Multiplexes NUM_PORTS valid/ready packet streams onto one registered output stream.
- Holds a grant for a whole packet (up_last-delimited). Forces a one-grant release after every packet so the arbiter's token rotates fairly.

Parameters:
NUM_PORTS, 6, number of upstream stream ports; must match the arbiter instance.
DATA_WIDTH, 32, width of one data beat.
PORT_WIDTH, 3, width of down_port index; ceil(log2(NUM_PORTS)), minimum 1.

Ports:
clk  input  1  clock; all state on rising edge.
rst  input  1  reset, active-low, asynchronous assert; release synchronised externally.
up_data  input  NUM_PORTS*DATA_WIDTH  port i beat at [i*DATA_WIDTH +: DATA_WIDTH].
up_valid  input  NUM_PORTS  per-port beat valid; bit i = port i.
up_last  input  NUM_PORTS  per-port end-of-packet flag, qualified by up_valid.
up_ready  output  NUM_PORTS  per-port beat accept.
request  output  [0:NUM_PORTS-1]  to arbiter; bit i = port i.
grant  input  [0:NUM_PORTS-1]  from arbiter (registered, one cycle after request).
active  input  1  from arbiter; |grant.
down_data  output  DATA_WIDTH  registered output beat.
down_valid  output  1  output beat valid.
down_last  output  1  end of packet on output.
down_port  output  PORT_WIDTH  source port index of the output beat.
down_ready  input  1  downstream accept.

Behaviour:
- Reset (rst=0, asynchronous):
  - State IDLE; owner=0; hold_off=0.
  - Outputs: down_valid=0, down_last=0, down_data=0, down_port=0, up_ready=0, request=0.
- request[i] = ((up_valid[i] | (state==BUSY & owner==i)) & ~hold_off[i]); combinational.
  - An owner's request stays high through mid-packet valid bubbles.
- States:
  - IDLE: if active, owner <= index of lowest set grant bit; go BUSY. Otherwise stay.
  - BUSY: transfers from port owner. On accepted beat with up_last[owner]=1: hold_off[owner] <= 1; go DRAIN.
  - DRAIN: no transfers; wait for grant[owner]==0. Then clear hold_off[owner] and go IDLE.
  - If grant[owner] drops while BUSY (arbiter misuse): abandon, go IDLE; the output register keeps any held beat.
- Accept rule:
  - up_ready[i] = (state==BUSY) & (owner==i) & grant[i] & (~down_valid | down_ready). All other bits are 0.
  - Beat accepted when up_valid[owner] & up_ready[owner].
- Output register:
  - On accept, load down_data, down_last and down_port=owner; set down_valid=1.
  - Else if down_ready, clear down_valid.
  - Latency is 1 cycle from accept to down_valid. Full throughput of 1 beat/cycle while down_ready=1.
  - down_* are stable while down_valid & ~down_ready.
- Release timing:
  - Last beat accepted at edge t, so hold_off is high after t.
  - The arbiter sees request[owner]=0 and rotates its token; grant[owner] falls after t+1.
  - DRAIN exits after t+2, and the next owner is captured in IDLE.
  - Minimum inter-packet gap is 3 cycles.
- Single-beat packet (up_last on the first beat): BUSY→DRAIN after one beat.
- Sole requester: the port is re-granted after DRAIN. It is not starved, and back-to-back packets still each get their own gap.
- Wrap-around of owner index follows the arbiter's rotation; this block performs no rotation itself.
- Simultaneous up_last accept and down_ready stall: the output register holds the beat; DRAIN proceeds independently.
- Reset mid-packet: immediate return to reset values. A partial packet already emitted is not terminated (no synthetic down_last).

Test Plan:
- Single port 2 streams a 4-beat packet (last on beat 4), down_ready=1:
  - request[2]=1; grant[2] one cycle later.
  - down_valid for 4 consecutive cycles, down_port=2, down_last on beat 4.
  - request[2]=0 for DRAIN, then re-raised.
- Ports 0, 1, 3 each hold a pending 2-beat packet:
  - Output packet order follows arbiter token rotation 0,1,3,0,…
  - No beats interleave between packets.
  - Gap of 3 cycles between packets.
- down_ready held 0 for 5 cycles mid-packet:
  - up_ready[owner]=0 while down_valid=1.
  - down_data stable; no beat lost or duplicated; count of down beats equals up beats.
- Owner port drops up_valid for 3 cycles mid-packet:
  - request[owner] stays 1, grant retained, no switch to other requesting ports.
  - The packet resumes intact.
- rst asserted while BUSY on port 4 mid-packet:
  - down_valid, up_ready and request are 0 in the same cycle.
  - After release, the state is IDLE and a fresh packet from port 1 passes normally.
- NUM_PORTS=1 (PORT_WIDTH=1):
  - Back-to-back 1-beat packets each produce down_last=1 and down_port=0, separated by the 3-cycle release gap.
